// File: rtl/count_enable_debouncer_if.sv
// count_enable_debouncer_if: raw button line in, debounced tick/level/release out
interface count_enable_debouncer_if;
  logic btn_in;
  logic tick_out;
  logic btn_level;
  logic release_out;
  modport master (output btn_in, input tick_out, btn_level, release_out);
  modport slave (input btn_in, output tick_out, btn_level, release_out);
endinterface

// File: rtl/count_enable_debouncer.sv
// count_enable_debouncer: debounces a raw button into a one-cycle count-enable tick; DEBOUNCE_AUTOREPEAT_EN adds hold-to-repeat ticks
module count_enable_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_RATE     = 10000
) (
  input logic clk,
  input logic rst,
  count_enable_debouncer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t r_state, w_next;
  logic r_s1, r_s2;
  logic [CNT_W-1:0] r_timer, w_timer, w_hold_timer;
  logic r_tick, r_level, r_release;
  logic w_tick, w_level, w_release, w_fire, w_deb_done;
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("count_enable_debouncer: invalid timing parameters");
  end
  assign w_deb_done = r_timer == CNT_W'(DEBOUNCE_CYCLES - 1);
  // two-flop synchronizer; the FSM only ever looks at r_s2
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= bus.btn_in;
      r_s2 <= r_s1;
    end
  end
  // state, timer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_tick    <= 1'b0;
      r_level   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      r_tick    <= w_tick;
      r_level   <= w_level;
      r_release <= w_release;
    end
  end
  // next state: a wait state falls back on any disagreeing sample
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:         w_next = r_s2 ? PRESS_WAIT : IDLE;
      PRESS_WAIT:   w_next = !r_s2 ? IDLE : w_deb_done ? PRESSED : PRESS_WAIT;
      PRESSED:      w_next = r_s2 ? PRESSED : RELEASE_WAIT;
      RELEASE_WAIT: w_next = r_s2 ? PRESSED : w_deb_done ? IDLE : RELEASE_WAIT;
      default:      w_next = IDLE;
    endcase
  end
`ifdef DEBOUNCE_AUTOREPEAT_EN
  logic r_phase, w_phase;
  // repeat phase: 0 waits REPEAT_DELAY after entering PRESSED, 1 repeats every REPEAT_RATE
  always_ff @(posedge clk) begin
    if (!rst) r_phase <= 1'b0;
    else      r_phase <= w_phase;
  end
  // repeat tick fires while staying in PRESSED; the timer doubles as the repeat counter there
  always_comb begin
    w_fire       = r_state == PRESSED && w_next == PRESSED &&
                   r_timer == (r_phase ? CNT_W'(REPEAT_RATE - 1) : CNT_W'(REPEAT_DELAY - 1));
    w_phase      = r_state == PRESSED && w_next == PRESSED && (r_phase || w_fire);
    w_hold_timer = w_fire ? '0 : r_timer + CNT_W'(1);
  end
`else
  assign w_fire       = 1'b0;
  assign w_hold_timer = '0;
`endif
  // outputs and timer: timer clears on every state change and only counts in wait/hold states
  always_comb begin
    w_tick    = (r_state == PRESS_WAIT && w_next == PRESSED) || w_fire;
    w_release = r_state == RELEASE_WAIT && w_next == IDLE;
    w_level   = w_next == PRESSED || w_next == RELEASE_WAIT;
    w_timer   = (w_next != r_state) ? '0 :
                (r_state == PRESS_WAIT || r_state == RELEASE_WAIT) ? r_timer + CNT_W'(1) :
                (r_state == PRESSED) ? w_hold_timer : '0;
  end
  assign bus.tick_out    = r_tick;
  assign bus.btn_level   = r_level;
  assign bus.release_out = r_release;
endmodule

// File: tb/tb_count_enable_debouncer.sv
// tb_count_enable_debouncer: randomized and directed checks against a run-length reference model
module tb_count_enable_debouncer;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int fails = 0;
  count_enable_debouncer_if bus ();
  count_enable_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16), .REPEAT_DELAY(RD), .REPEAT_RATE(RR))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // reference: the input seen two edges late; a level flips once it has disagreed for DEB+1 edges in a row
  logic m_d1 = 1'b0, m_d2 = 1'b0, m_lvl = 1'b0;
  int m_run = 0, m_hold = 0;
  logic e_tick = 1'b0, e_lvl = 1'b0, e_rel = 1'b0;
  task automatic step(input logic b, input logic r);
    logic s;
    bus.btn_in = b;
    rst = r;
    if (!r) begin
      m_d1 = 0; m_d2 = 0; m_lvl = 0; m_run = 0; m_hold = 0;
      e_tick = 0; e_lvl = 0; e_rel = 0;
    end else begin
      s = m_d2; m_d2 = m_d1; m_d1 = b;
      e_tick = 0; e_rel = 0;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = s; m_run = 0; m_hold = 0;
          e_tick = s; e_rel = !s;
        end
      end else if (m_run > 0) begin
        m_run = 0; m_hold = 0;
      end else if (m_lvl) begin
        m_hold++;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        if (m_hold >= RD && (m_hold - RD) % RR == 0) e_tick = 1;
`endif
      end
      e_lvl = m_lvl;
    end
    @(negedge clk);
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== 3'b000) begin
        fails++;
        $display("FAIL reset[%0d] got tick/lvl/rel=%b%b%b exp 000", i, bus.tick_out, bus.btn_level, bus.release_out);
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} || bus.tick_out !== (i == 6)) begin
        fails++;
        $display("FAIL reset_press[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b tick@6", i, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
  endtask
  task automatic test_press;
    int ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      ticks += int'(bus.tick_out);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} || bus.btn_level !== (i >= 6)) begin
        fails++;
        $display("FAIL press[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b", i, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
      end
    end
`ifndef DEBOUNCE_AUTOREPEAT_EN
    vectors++;
    if (ticks !== 1) begin
      fails++;
      $display("FAIL press_tick_count got %0d exp 1", ticks);
    end
`endif
  endtask
  task automatic test_release;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} ||
          bus.release_out !== (i == 6) || bus.btn_level !== (i < 6)) begin
        fails++;
        $display("FAIL release[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b", i, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
      end
    end
  endtask
  task automatic test_glitch_pulses;
    logic [15:0] pat = 16'b1011_0111_0000_0000;
    for (int i = 0; i < 16; i++) begin
      step(pat[15 - i], 1'b1);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} || {bus.tick_out, bus.btn_level} !== 2'b00) begin
        fails++;
        $display("FAIL glitch[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b", i, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
      end
    end
  endtask
  task automatic test_release_glitch;
    logic [21:0] pat = 22'b1111111111_00_1111111111;
    for (int i = 0; i < 22; i++) begin
      step(pat[21 - i], 1'b1);
      vectors++;
      if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} ||
          (i > 6 && {bus.tick_out, bus.btn_level, bus.release_out} !== 3'b010)) begin
        fails++;
        $display("FAIL rel_glitch[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b", i, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
  endtask
`ifdef DEBOUNCE_AUTOREPEAT_EN
  task automatic test_autorepeat;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1);
      vectors++;
      if (bus.tick_out !== (i == 6 || (i >= 6 + RD && (i - 6 - RD) % RR == 0)) || bus.tick_out !== e_tick) begin
        fails++;
        $display("FAIL autorepeat[%0d] got tick=%b exp %b", i, bus.tick_out, e_tick);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      vectors++;
      if (bus.tick_out !== 1'b0 || bus.release_out !== e_rel) begin
        fails++;
        $display("FAIL autorepeat_rel[%0d] got tick/rel=%b%b exp 0%b", i, bus.tick_out, bus.release_out, e_rel);
      end
    end
  endtask
`endif
  task automatic test_random;
    int n = 0;
    int len;
    logic b;
    logic prev_tick = 1'b0;
    while (n < 3000) begin
      b = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 40) : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        step(b, $urandom_range(0, 199) != 0);
        vectors++;
        if ({bus.tick_out, bus.btn_level, bus.release_out} !== {e_tick, e_lvl, e_rel} || (prev_tick && bus.tick_out)) begin
          fails++;
          $display("FAIL random[%0d] got tick/lvl/rel=%b%b%b exp %b%b%b", n, bus.tick_out, bus.btn_level, bus.release_out, e_tick, e_lvl, e_rel);
        end
        prev_tick = bus.tick_out;
        n++;
      end
    end
  endtask
  initial begin
    bus.btn_in = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_glitch_pulses();
    test_release_glitch();
`ifdef DEBOUNCE_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
